// File: rtl/fp_dot_pkg.sv
// Shared types and constants for the floating-point dot-product accumulator.
package fp_dot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_INVALID = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  localparam logic [2:0] RNE = 3'd0;
  localparam logic [2:0] RTZ = 3'd1;
  localparam logic [2:0] RUP = 3'd2;
  localparam logic [2:0] RDN = 3'd3;

endpackage

// File: rtl/DW_fp_mac.sv
// Single-cycle fused multiply-add z = a*b + c with one final rounding.
// Denormal inputs/outputs flush to zero; NaN inputs are recognised only with ieee_compliance.
module DW_fp_mac
  import fp_dot_pkg::*;
#(
  parameter int sig_width       = 23,
  parameter int exp_width       = 8,
  parameter int ieee_compliance = 0
) (
  input  logic [sig_width+exp_width:0] a,
  input  logic [sig_width+exp_width:0] b,
  input  logic [sig_width+exp_width:0] c,
  input  logic [2:0]                   rnd,
  output logic [sig_width+exp_width:0] z,
  output logic [7:0]                   status
);

  localparam int PW   = 2 * sig_width + 2;
  localparam int G    = 3;
  localparam int N    = PW + G;
  localparam int BIAS = (1 << (exp_width - 1)) - 1;
  localparam int EMAX = (1 << exp_width) - 1;

  logic                 sa, sb, sc, sp;
  logic [exp_width-1:0] ea, eb, ec;
  logic [sig_width:0]   ma, mb, mc;
  logic                 a_zero, b_zero, c_zero, p_zero;
  logic                 a_nan, b_nan, c_nan, a_inf, b_inf, c_inf, p_inf;
  logic                 invalid;
  logic [PW-1:0]        pm;
  logic [N-1:0]         p_al, c_al;
  int                   ep, ecx;

  assign sa = a[sig_width+exp_width];
  assign sb = b[sig_width+exp_width];
  assign sc = c[sig_width+exp_width];
  assign sp = sa ^ sb;
  assign ea = a[sig_width +: exp_width];
  assign eb = b[sig_width +: exp_width];
  assign ec = c[sig_width +: exp_width];
  assign ma = {1'b1, a[sig_width-1:0]};
  assign mb = {1'b1, b[sig_width-1:0]};
  assign mc = {1'b1, c[sig_width-1:0]};

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign c_zero = (ec == '0);
  assign p_zero = a_zero | b_zero;
  assign a_nan  = (&ea) && (ieee_compliance != 0) && (|a[sig_width-1:0]);
  assign b_nan  = (&eb) && (ieee_compliance != 0) && (|b[sig_width-1:0]);
  assign c_nan  = (&ec) && (ieee_compliance != 0) && (|c[sig_width-1:0]);
  assign a_inf  = (&ea) && !a_nan;
  assign b_inf  = (&eb) && !b_nan;
  assign c_inf  = (&ec) && !c_nan;
  assign p_inf  = a_inf | b_inf;
  assign invalid = a_nan | b_nan | c_nan | (a_inf & b_zero) | (b_inf & a_zero)
                 | (p_inf & c_inf & (sp != sc));

  // Product and addend share one fixed-point frame: 2*sig_width fraction bits plus guard bits.
  assign pm   = PW'(ma) * PW'(mb);
  assign p_al = {pm, {G{1'b0}}};
  assign c_al = {1'b0, mc, {sig_width{1'b0}}, {G{1'b0}}};
  assign ep   = int'(ea) + int'(eb) - BIAS;
  assign ecx  = int'(ec);

  function automatic logic [N-1:0] shr_sticky(input logic [N-1:0] x, input int s);
    logic [N-1:0] mask;
    mask = ~({N{1'b1}} << s);
    return (x >> s) | N'(|(x & mask));
  endfunction

  logic [N-1:0]         p_op, c_op;
  logic [N:0]           sum, norm;
  logic                 rs, rbit, stk, inc, to_inf;
  logic [sig_width-1:0] frac;
  logic [sig_width+1:0] mant;
  int                   d, base, sh, lead, lz, e_res;

  always_comb begin
    z      = '0;
    status = '0;
    p_op   = '0;
    c_op   = '0;
    sum    = '0;
    rs     = 1'b0;
    base   = 0;
    sh     = 0;
    lead   = 0;
    d      = ep - ecx;

    // Align the smaller-exponent operand; the shifted-out bits collapse into its lsb.
    if (c_zero || (!p_zero && d >= 0)) begin
      base = ep;
      sh   = c_zero ? 0 : ((d > N) ? N + 1 : d);
      p_op = p_zero ? '0 : p_al;
      c_op = c_zero ? '0 : shr_sticky(c_al, sh);
    end else begin
      base = ecx;
      sh   = (-d > N) ? N + 1 : -d;
      p_op = p_zero ? '0 : shr_sticky(p_al, sh);
      c_op = c_al;
    end

    if (sp == sc) begin
      sum = {1'b0, p_op} + {1'b0, c_op};
      rs  = sp;
    end else if (p_op >= c_op) begin
      sum = {1'b0, p_op - c_op};
      rs  = sp;
    end else begin
      sum = {1'b0, c_op - p_op};
      rs  = sc;
    end

    for (int i = 0; i <= N; i++) begin
      if (sum[i]) lead = i;
    end
    lz    = N - lead;
    norm  = sum << lz;
    e_res = base + 2 - lz;
    frac  = norm[N-1 -: sig_width];
    rbit  = norm[N-1-sig_width];
    stk   = |norm[N-2-sig_width:0];

    case (rnd)
      RNE:     inc = rbit & (stk | frac[0]);
      RTZ:     inc = 1'b0;
      RUP:     inc = !rs & (rbit | stk);
      RDN:     inc = rs & (rbit | stk);
      3'd4:    inc = rbit;
      3'd5:    inc = rbit | stk;
      default: inc = 1'b0;
    endcase
    to_inf = (rnd == RNE) || (rnd == 3'd4) || (rnd == 3'd5)
          || (rnd == RUP && !rs) || (rnd == RDN && rs);

    mant = {2'b01, frac} + (sig_width + 2)'(inc);
    if (mant[sig_width+1]) begin
      e_res = e_res + 1;
      frac  = '0;
    end else begin
      frac  = mant[sig_width-1:0];
    end

    if (invalid) begin
      z = {1'b0, {exp_width{1'b1}}, 1'b1, {(sig_width-1){1'b0}}};
      status[ST_INVALID] = 1'b1;
    end else if (p_inf || c_inf) begin
      z = {(p_inf ? sp : sc), {exp_width{1'b1}}, {sig_width{1'b0}}};
      status[ST_INF] = 1'b1;
    end else if (p_zero && c_zero) begin
      z = {((sp == sc) ? sp : (rnd == RDN)), {(exp_width+sig_width){1'b0}}};
      status[ST_ZERO] = 1'b1;
    end else if (p_zero) begin
      z = c;
    end else if (sum == '0) begin
      z = {(rnd == RDN), {(exp_width+sig_width){1'b0}}};
      status[ST_ZERO] = 1'b1;
    end else if (e_res >= EMAX) begin
      status[ST_HUGE]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
      if (to_inf) begin
        z = {rs, {exp_width{1'b1}}, {sig_width{1'b0}}};
        status[ST_INF] = 1'b1;
      end else begin
        z = {rs, exp_width'(EMAX - 1), {sig_width{1'b1}}};
      end
    end else if (e_res <= 0) begin
      z = {rs, {(exp_width+sig_width){1'b0}}};
      status[ST_ZERO]    = 1'b1;
      status[ST_TINY]    = 1'b1;
      status[ST_INEXACT] = 1'b1;
    end else begin
      z = {rs, e_res[exp_width-1:0], frac};
      status[ST_INEXACT] = rbit | stk;
    end
  end

endmodule

// File: rtl/fp_dot_acc.sv
// Streams (a, b) pairs through one FMA, accumulating acc <- a*b + acc for len beats,
// then holds the rounded sum and the OR-accumulated exception flags until taken.
module fp_dot_acc
  import fp_dot_pkg::*;
#(
  parameter int SIG_WIDTH       = 23,
  parameter int EXP_WIDTH       = 8,
  parameter int IEEE_COMPLIANCE = 0,
  parameter int LEN_WIDTH       = 8
) (
  input  logic                           inst_clk,
  input  logic                           inst_rst_n,
  input  logic [2:0]                     inst_rnd,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]   in_a,
  input  logic [SIG_WIDTH+EXP_WIDTH:0]   in_b,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SIG_WIDTH+EXP_WIDTH:0]   z,
  output logic [7:0]                     status,
  output logic                           busy,
  output state_t                         dbg_state
);

  localparam int W = SIG_WIDTH + EXP_WIDTH + 1;

  // Handshake: a pair moves when in_valid && in_ready (ACC only); a result moves when
  // out_valid && out_ready (DONE only). Both ready/valid outputs decode from state alone.
  state_t               state;
  logic [W-1:0]         acc;
  logic [LEN_WIDTH-1:0] cnt;
  logic [7:1]           sticky;
  logic                 last0;
  logic [2:0]           rnd_q;
  logic [W-1:0]         fma_z;
  logic [7:0]           fma_status;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  DW_fp_mac #(
    .sig_width      (SIG_WIDTH),
    .exp_width      (EXP_WIDTH),
    .ieee_compliance(IEEE_COMPLIANCE)
  ) u_mac (
    .a     (in_a),
    .b     (in_b),
    .c     (acc),
    .rnd   (rnd_q),
    .z     (fma_z),
    .status(fma_status)
  );

  always_ff @(posedge inst_clk or negedge inst_rst_n) begin
    if (!inst_rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      sticky <= '0;
      last0  <= 1'b0;
      rnd_q  <= RNE;
      z      <= '0;
      status <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rnd_q <= inst_rnd;
            if (len != '0) begin
              acc    <= '0;
              sticky <= '0;
              last0  <= 1'b0;
              cnt    <= len;
              state  <= ACC;
            end else begin
              // An empty vector sums to +0, flagged as an exact zero.
              z      <= '0;
              status <= 8'h01;
              state  <= DONE;
            end
          end
        end
        ACC: begin
          if (in_valid && in_ready) begin
            acc    <= fma_z;
            sticky <= sticky | fma_status[7:1];
            last0  <= fma_status[0];
            cnt    <= cnt - 1'b1;
            if (cnt == LEN_WIDTH'(1)) begin
              z      <= fma_z;
              status <= {sticky | fma_status[7:1], fma_status[0]};
              state  <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_dot_acc.md
# fp_dot_acc

Sequential dot-product accumulator built around the team's single-cycle floating-point fused multiply-add. It accepts a stream of (a, b) operand pairs over a valid/ready handshake and drives the FMA's c operand from its own accumulator register. Each beat computes acc ← a·b + acc. After `len` beats it presents the rounded sum and the accumulated exception status downstream. It sits between the operand-fetch stream and the result writeback.

## Interface
Parameters:
- `SIG_WIDTH`, default 23: significand width, passed to the FMA.
- `EXP_WIDTH`, default 8: exponent width, passed to the FMA.
- `IEEE_COMPLIANCE`, default 0: passed to the FMA.
- `LEN_WIDTH`, default 8: width of the vector-length field.
- W = SIG_WIDTH+EXP_WIDTH+1, derived.

Ports:
- `inst_clk` in 1: clock, rising edge.
- `inst_rst_n` in 1: reset, asynchronous, active-low.
- `inst_rnd` in 3: rounding mode, sampled at start.
- `start` in 1: begin a new dot product. Honoured only in IDLE.
- `len` in LEN_WIDTH: number of pairs, sampled with start.
- `in_valid` in 1: an operand pair is present.
- `in_ready` out 1: the block accepts a pair.
- `in_a`, `in_b` in W: operands.
- `out_valid` out 1: result available.
- `out_ready` in 1: downstream accepts the result.
- `z` out W: final sum.
- `status` out 8: FMA-format status flags.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, ACC, DONE.
- IDLE, on `start` with `len`≠0:
  - acc ← +0 (all zeros);
  - sticky ← 0;
  - cnt ← len;
  - rnd_q ← inst_rnd;
  - next state ACC.
- IDLE, on `start` with `len`=0: z ← +0, status ← 8'h01, next state DONE.
- ACC:
  - `in_ready`=1.
  - A beat is accepted when in_valid && in_ready.
  - On each accepted beat: acc ← FMA(in_a, in_b, acc, rnd_q); sticky[7:1] |= fma_status[7:1]; last0 ← fma_status[0]; cnt ← cnt−1.
  - The beat accepted with cnt==1 moves the FSM to DONE.
  - With no accepted beat, all registers hold.
- DONE:
  - `out_valid`=1, z=acc, status={sticky[7:1], last0}.
  - When out_ready is high, the FSM returns to IDLE.
  - z and status hold stable while out_ready is low.
- `start` outside IDLE is ignored, with no error flag. `start` in the same cycle as DONE handoff is also ignored; it is accepted on the next cycle in IDLE.
- `in_ready` is 0 in IDLE and DONE. Operands presented then are not consumed.
- `len`=2^LEN_WIDTH−1 is the maximum. cnt never wraps, because exit occurs at cnt==1.
- NaN and Inf propagate through acc per the FMA.
- The status bit order follows the FMA: [0] zero, [1] inf, [2] invalid, [3] tiny, [4] huge, [5] inexact, [7:6] reserved pass-through.

## Timing
- Reset values:
  - state IDLE;
  - in_ready 0, out_valid 0, busy 0;
  - z 0, status 0;
  - acc 0, cnt 0, sticky 0.
- Assertion of `inst_rst_n` mid-operation aborts the current operation. No result is produced, and the next start begins clean.
- The FMA is combinational between acc and the operand inputs, so the block sustains one pair per cycle.
- Latency for a len=N operation with back-to-back beats: start at cycle 0, beats at cycles 1..N, out_valid at cycle N+1.
- With len=0, out_valid is asserted the cycle after start.
- Minimum spacing between results is N+2 cycles (start, N beats, DONE handoff).
- All outputs are registered or decoded from state only. There is no combinational path from in_valid to in_ready or from out_ready to out_valid.

## Structure
- Package `fp_dot_pkg` holds:
  - the state enum (IDLE, ACC, DONE);
  - status bit index constants (ST_ZERO … ST_INEXACT);
  - the rounding-mode constants (RNE=3'd0, RTZ=3'd1, RUP=3'd2, RDN=3'd3).
- Single sub-module: one `DW_fp_mac` instance with the parameters passed through, c tied to acc and rnd tied to rnd_q. No other hierarchy.

## Test plan
All values are single precision with defaults.
1. len=2, rnd=0, pairs (3F800000,40400000), (40000000,40800000) back-to-back → out_valid at cycle 3, z=41300000 (11.0), status=8'h00.
2. len=0 → out_valid next cycle, z=00000000, status=8'h01. in_ready stays 0 throughout.
3. len=1, pair (7F7FFFFF,7F7FFFFF), rnd=0 → z=7F800000, status=8'h32 (inf|huge|inexact).
4. Backpressure test, in two parts:
   - len=3 with in_valid toggled every other cycle: only accepted beats are counted, and the result equals the unstalled run.
   - out_ready held low for 5 cycles: z and status are stable, and start is ignored.
5. `start` pulsed during ACC with a different len: no effect, and the original len completes.
6. `inst_rst_n` asserted after 1 of 3 beats: all outputs return to reset values immediately. A new len=1 run of (3F800000,3F800000) then yields z=3F800000, with no residue from the aborted operation.
